// File: rtl/slow_ddr_pipeline_limiter.sv
// Avalon-MM command/return pipeline stage ahead of the slow DDR clock-crossing bridge.
// Caps outstanding reads at MAX_PENDING; define SLOW_DDR_LIMITER_STATS_EN for traffic counters.
module slow_ddr_pipeline_limiter #(
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 8,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     s_address,
  input  logic [ADDR_W-1:0]     s_nativeaddress,
  input  logic [DATA_W/8-1:0]   s_byteenable,
  input  logic                  s_read,
  input  logic                  s_write,
  input  logic [DATA_W-1:0]     s_writedata,
  output logic                  s_waitrequest,
  output logic [DATA_W-1:0]     s_readdata,
  output logic                  s_readdatavalid,
  output logic                  s_endofpacket,
  output logic [ADDR_W-1:0]     m_address,
  output logic [ADDR_W-1:0]     m_nativeaddress,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic                  m_read,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  input  logic                  m_waitrequest,
  input  logic [DATA_W-1:0]     m_readdata,
  input  logic                  m_readdatavalid,
  input  logic                  m_endofpacket,
  output logic                  err_unexpected_rdv
`ifdef SLOW_DDR_LIMITER_STATS_EN
  ,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes,
  output logic [31:0]           stat_stall_cycles
`endif
);

  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] pending_nxt;
  logic             cmd_valid;
  logic             hold;
  logic             rd_block;
  logic             accept;
  logic             acc_rd;
  logic             acc_wr;

  assign cmd_valid     = m_read | m_write;
  assign hold          = cmd_valid & m_waitrequest;
  assign rd_block      = (pending == CNT_W'(MAX_PENDING));
  assign s_waitrequest = hold | (s_read & ~s_write & rd_block);
  assign accept        = (s_read | s_write) & ~s_waitrequest;
  // A simultaneous read+write is taken as a write; the read is discarded.
  assign acc_rd        = accept & s_read & ~s_write;
  assign acc_wr        = accept & s_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_address       <= '0;
      m_nativeaddress <= '0;
      m_byteenable    <= '0;
      m_read          <= 1'b0;
      m_write         <= 1'b0;
      m_writedata     <= '0;
    end else if (accept) begin
      m_address       <= s_address;
      m_nativeaddress <= s_nativeaddress;
      m_byteenable    <= s_byteenable;
      m_read          <= s_read & ~s_write;
      m_write         <= s_write;
      m_writedata     <= s_writedata;
    end else if (!hold) begin
      m_read  <= 1'b0;
      m_write <= 1'b0;
    end
  end

  // Underflowing returns leave the count at zero rather than wrapping.
  always_comb begin
    pending_nxt = pending;
    unique case ({acc_rd, m_readdatavalid})
      2'b10:   pending_nxt = pending + 1'b1;
      2'b01:   if (pending != '0) pending_nxt = pending - 1'b1;
      default: pending_nxt = pending;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending            <= '0;
      err_unexpected_rdv <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (m_readdatavalid && pending == '0)
        err_unexpected_rdv <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_readdata      <= '0;
      s_readdatavalid <= 1'b0;
      s_endofpacket   <= 1'b0;
    end else begin
      s_readdata      <= m_readdata;
      s_readdatavalid <= m_readdatavalid;
      s_endofpacket   <= m_endofpacket;
    end
  end

`ifdef SLOW_DDR_LIMITER_STATS_EN
  logic stall_cycle;
  assign stall_cycle = (s_read | s_write) & s_waitrequest;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_reads        <= '0;
      stat_writes       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (acc_rd && stat_reads != '1)
        stat_reads <= stat_reads + 32'd1;
      if (acc_wr && stat_writes != '1)
        stat_writes <= stat_writes + 32'd1;
      if (stall_cycle && stat_stall_cycles != '1)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_slow_ddr_pipeline_limiter.sv
// Directed scoreboard bench for slow_ddr_pipeline_limiter (default parameters).
module tb_slow_ddr_pipeline_limiter;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;

  typedef struct {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] naddr;
    logic [3:0]        be;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              eop;
    int                due;
  } ret_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] s_address = '0;
  logic [ADDR_W-1:0] s_nativeaddress = '0;
  logic [3:0]        s_byteenable = '0;
  logic              s_read = 1'b0;
  logic              s_write = 1'b0;
  logic [DATA_W-1:0] s_writedata = '0;
  logic              s_waitrequest;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;
  logic              s_endofpacket;
  logic [ADDR_W-1:0] m_address;
  logic [ADDR_W-1:0] m_nativeaddress;
  logic [3:0]        m_byteenable;
  logic              m_read;
  logic              m_write;
  logic [DATA_W-1:0] m_writedata;
  logic              m_waitrequest = 1'b0;
  logic [DATA_W-1:0] m_readdata = '0;
  logic              m_readdatavalid = 1'b0;
  logic              m_endofpacket = 1'b0;
  logic              err_unexpected_rdv;
`ifdef SLOW_DDR_LIMITER_STATS_EN
  logic [31:0]       stat_reads;
  logic [31:0]       stat_writes;
  logic [31:0]       stat_stall_cycles;
`endif

  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc_n = 0;
  cmd_t exp_cmd[$];
  ret_t exp_ret[$];

  slow_ddr_pipeline_limiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(8), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .s_address(s_address), .s_nativeaddress(s_nativeaddress),
    .s_byteenable(s_byteenable), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .s_endofpacket(s_endofpacket),
    .m_address(m_address), .m_nativeaddress(m_nativeaddress),
    .m_byteenable(m_byteenable), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_endofpacket(m_endofpacket),
    .err_unexpected_rdv(err_unexpected_rdv)
`ifdef SLOW_DDR_LIMITER_STATS_EN
    ,
    .stat_reads(stat_reads), .stat_writes(stat_writes),
    .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [3:0] be, input logic [DATA_W-1:0] data);
    s_read          = rd;
    s_write         = wr;
    s_address       = addr;
    s_nativeaddress = addr ^ 23'h400000;
    s_byteenable    = be;
    s_writedata     = data;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Expected bridge command for whatever is currently driven on s_*.
  task automatic push_cmd();
    cmd_t c;
    c.rd    = s_read & ~s_write;
    c.wr    = s_write;
    c.addr  = s_address;
    c.naddr = s_nativeaddress;
    c.be    = s_byteenable;
    c.data  = s_writedata;
    exp_cmd.push_back(c);
  endtask

  task automatic bridge_return(input logic [DATA_W-1:0] data, input logic eop);
    ret_t r;
    m_readdatavalid = 1'b1;
    m_readdata      = data;
    m_endofpacket   = eop;
    r.data = data;
    r.eop  = eop;
    r.due  = cyc_n + 1;
    exp_ret.push_back(r);
  endtask

  // Command scoreboard: a command leaves when presented without m_waitrequest.
  always @(negedge clk) begin
    if ((m_read || m_write) && !m_waitrequest) begin
      if (exp_cmd.size() == 0) begin
        check("cmd_unexpected", {m_read, m_write}, 2'b00);
      end else begin
        cmd_t c;
        c = exp_cmd.pop_front();
        check("cmd_read", m_read, c.rd);
        check("cmd_write", m_write, c.wr);
        check("cmd_addr", m_address, c.addr);
        check("cmd_naddr", m_nativeaddress, c.naddr);
        check("cmd_be", m_byteenable, c.be);
        check("cmd_data", m_writedata, c.data);
      end
    end
  end

  // Return scoreboard: each beat must appear exactly one cycle after the bridge gave it.
  always @(negedge clk) begin
    if (s_readdatavalid) begin
      if (exp_ret.size() == 0) begin
        check("ret_unexpected", s_readdatavalid, 1'b0);
      end else begin
        ret_t r;
        r = exp_ret.pop_front();
        check("ret_cycle", cyc_n, r.due);
        check("ret_data", s_readdata, r.data);
        check("ret_eop", s_endofpacket, r.eop);
      end
    end
  end

  initial begin
    idle();
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    check("rst_m_read", m_read, 1'b0);
    check("rst_m_write", m_write, 1'b0);
    check("rst_s_rdv", s_readdatavalid, 1'b0);
    check("rst_err", err_unexpected_rdv, 1'b0);
    check("rst_waitreq", s_waitrequest, 1'b0);
    check("rst_pending", dut.pending, 4'd0);

    // Single write
    drive(1'b0, 1'b1, 23'h000010, 4'hF, 32'h12345678);
    #1;
    check("wr_waitreq", s_waitrequest, 1'b0);
    push_cmd();
    cyc();
    idle();
    #1;
    check("wr_m_write", m_write, 1'b1);
    check("wr_m_addr", m_address, 23'h000010);
    check("wr_m_data", m_writedata, 32'h12345678);
    check("wr_waitreq_after", s_waitrequest, 1'b0);
    cyc();
    check("wr_one_cycle", m_write, 1'b0);

    // Nine back-to-back reads with no returns: the ninth stalls
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 23'h000100 + 23'(i), 4'h3, '0);
      #1;
      check("rd_fill_waitreq", s_waitrequest, (i == 8));
      if (i != 8) push_cmd();
      cyc();
    end
    check("rd_full_pending", dut.pending, 4'd8);
    // Read+write together counts as a write and is not blocked by the read cap
    drive(1'b1, 1'b1, 23'h000200, 4'hC, 32'h22220000);
    #1;
    check("rw_waitreq", s_waitrequest, 1'b0);
    push_cmd();
    cyc();
    check("rw_pending", dut.pending, 4'd8);
    drive(1'b1, 1'b0, 23'h000108, 4'h3, '0);
    #1;
    check("rd9_stall", s_waitrequest, 1'b1);
    bridge_return(32'hA0A0A0A0, 1'b0);
    #1;
    check("rd9_stall_same_cycle", s_waitrequest, 1'b1);
    cyc();
    m_readdatavalid = 1'b0;
    #1;
    check("rd9_released", s_waitrequest, 1'b0);
    check("rd9_pending7", dut.pending, 4'd7);
    push_cmd();
    cyc();
    idle();
    check("rd9_m_read", m_read, 1'b1);
    check("rd9_m_addr", m_address, 23'h000108);
    check("rd9_pending8", dut.pending, 4'd8);

    for (int i = 0; i < 8; i++) begin
      bridge_return(32'hC0000000 + 32'(i), (i == 7));
      cyc();
    end
    m_readdatavalid = 1'b0;
    m_endofpacket = 1'b0;
    check("drain_pending", dut.pending, 4'd0);
    check("drain_err", err_unexpected_rdv, 1'b0);

    // Bridge stall for three cycles with a write queued behind a read
    drive(1'b1, 1'b0, 23'h0000AA, 4'h5, '0);
    #1;
    check("hold_rd_waitreq", s_waitrequest, 1'b0);
    push_cmd();
    cyc();
    drive(1'b0, 1'b1, 23'h000055, 4'hF, 32'h5555AAAA);
    for (int k = 0; k < 3; k++) begin
      m_waitrequest = 1'b1;
      #1;
      check("hold_m_read", m_read, 1'b1);
      check("hold_m_addr", m_address, 23'h0000AA);
      check("hold_m_be", m_byteenable, 4'h5);
      check("hold_waitreq", s_waitrequest, 1'b1);
      cyc();
    end
    m_waitrequest = 1'b0;
    #1;
    check("hold_release_waitreq", s_waitrequest, 1'b0);
    push_cmd();
    cyc();
    idle();
    check("hold_wr_m_write", m_write, 1'b1);
    check("hold_wr_m_read", m_read, 1'b0);
    check("hold_wr_m_addr", m_address, 23'h000055);
    cyc();

    // Return with end-of-packet
    check("eop_pre_rdv", s_readdatavalid, 1'b0);
    bridge_return(32'hDEADBEEF, 1'b1);
    cyc();
    m_readdatavalid = 1'b0;
    m_endofpacket = 1'b0;
    check("eop_rdv", s_readdatavalid, 1'b1);
    check("eop_data", s_readdata, 32'hDEADBEEF);
    check("eop_eop", s_endofpacket, 1'b1);
    check("eop_pending", dut.pending, 4'd0);
    cyc();
    check("eop_rdv_gone", s_readdatavalid, 1'b0);

    // Return with nothing pending
    bridge_return(32'h0BADF00D, 1'b0);
    cyc();
    m_readdatavalid = 1'b0;
    check("unexp_err", err_unexpected_rdv, 1'b1);
    check("unexp_pending", dut.pending, 4'd0);
    check("unexp_fwd", s_readdata, 32'h0BADF00D);
    cyc();
    check("unexp_sticky", err_unexpected_rdv, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("unexp_cleared", err_unexpected_rdv, 1'b0);

    // Reset with five reads pending and the last one held by the bridge
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 23'h000300 + 23'(i), 4'h9, '0);
      #1;
      check("rst_fill_waitreq", s_waitrequest, 1'b0);
      push_cmd();
      cyc();
    end
    m_waitrequest = 1'b1;
    drive(1'b1, 1'b0, 23'h0003FF, 4'h6, '0);
    reset = 1'b1;
    #1;
    check("rst5_hold", s_waitrequest, 1'b1);
    check("rst5_pending", dut.pending, 4'd5);
    check("rst5_m_read", m_read, 1'b1);
    void'(exp_cmd.pop_back());
    cyc();
    check("rst5_m_read_clr", m_read, 1'b0);
    check("rst5_m_write_clr", m_write, 1'b0);
    check("rst5_m_addr_clr", m_address, 23'h0);
    check("rst5_s_rdv_clr", s_readdatavalid, 1'b0);
    check("rst5_s_data_clr", s_readdata, 32'h0);
    check("rst5_err_clr", err_unexpected_rdv, 1'b0);
    check("rst5_pending_clr", dut.pending, 4'd0);
    reset = 1'b0;
    m_waitrequest = 1'b0;
    #1;
    check("post_rst_waitreq", s_waitrequest, 1'b0);
    push_cmd();
    cyc();
    idle();
    check("post_rst_m_read", m_read, 1'b1);
    check("post_rst_m_addr", m_address, 23'h0003FF);
    check("post_rst_pending", dut.pending, 4'd1);
    cyc();
    bridge_return(32'h13579BDF, 1'b1);
    cyc();
    m_readdatavalid = 1'b0;
    m_endofpacket = 1'b0;
    cyc();
    check("final_pending", dut.pending, 4'd0);
    check("cmd_queue_left", exp_cmd.size(), 0);
    check("ret_queue_left", exp_ret.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
